// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the next-level memory arbiter: request/response structs and arbiter enums.
package cache_mem_arbiter_pkg;

   localparam int unsigned MEM_ADDR_W = 32;
   localparam int unsigned MEM_LINE_W = 128;

   typedef struct packed {
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_LINE_W-1:0] data;
      logic                  rw;
      logic                  valid;
   } mem_req_type;

   typedef struct packed {
      logic [MEM_LINE_W-1:0] data;
      logic                  ready;
   } mem_data_type;

   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_type;
   typedef enum logic {OWN_I, OWN_D} arb_owner_type;

endpackage

// File: rtl/arb_rr2.sv
// Two-way combinational picker; index 0 = I, 1 = D. One-hot grant.
module arb_rr2 (
   input  logic [1:0] req_i,
   input  logic       rr_ptr_i,
   input  logic       fixed_prio_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = req_i;
      // Contention: fixed priority favours D, otherwise the pointer decides.
      if (req_i == 2'b11) begin
         gnt_o = (fixed_prio_i || rr_ptr_i) ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the next-level memory port between the I-cache and D-cache FSMs,
// one registered transaction at a time.
module cache_mem_arbiter
   import cache_mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned LINE_W     = 128,
   parameter bit          FIXED_PRIO = 1'b0,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  mem_req_type      i_req_i,
   output mem_data_type     i_res_o,
   input  mem_req_type      d_req_i,
   output mem_data_type     d_res_o,
   output mem_req_type      mem_req_o,
   input  mem_data_type     mem_res_i,
   output logic             busy_o,
   output logic             owner_o,
   output logic [CNT_W-1:0] no_grant_i_o,
   output logic [CNT_W-1:0] no_grant_d_o
);

   arb_state_type    state_q, state_d;
   arb_owner_type    owner_q, owner_d;
   logic             rr_ptr_q, rr_ptr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] data_q, data_d;
   logic             rw_q, rw_d;
   logic [CNT_W-1:0] cnt_i_q, cnt_i_d;
   logic [CNT_W-1:0] cnt_d_q, cnt_d_d;
   logic [1:0]       gnt;
   mem_req_type      win_req;

   arb_rr2 u_arb_rr2 (
      .req_i        ({d_req_i.valid, i_req_i.valid}),
      .rr_ptr_i     (rr_ptr_q),
      .fixed_prio_i (FIXED_PRIO),
      .gnt_o        (gnt)
   );

   assign win_req = gnt[1] ? d_req_i : i_req_i;

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      addr_d   = addr_q;
      data_d   = data_q;
      rw_d     = rw_q;
      cnt_i_d  = cnt_i_q;
      cnt_d_d  = cnt_d_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (gnt != 2'b00) begin
               state_d = ARB_BUSY;
               owner_d = gnt[1] ? OWN_D : OWN_I;
               addr_d  = win_req.addr;
               data_d  = win_req.data;
               rw_d    = win_req.rw;
               if (gnt[1]) cnt_d_d = cnt_d_q + CNT_W'(1);
               else        cnt_i_d = cnt_i_q + CNT_W'(1);
               // Pointer hands priority to whichever side lost this round.
               if (!FIXED_PRIO) rr_ptr_d = gnt[0];
            end
         end
         ARB_BUSY: begin
            if (mem_res_i.ready) state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ARB_IDLE;
         owner_q  <= OWN_I;
         rr_ptr_q <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         rw_q     <= 1'b0;
         cnt_i_q  <= '0;
         cnt_d_q  <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         rw_q     <= rw_d;
         cnt_i_q  <= cnt_i_d;
         cnt_d_q  <= cnt_d_d;
      end
   end

   always_comb begin
      mem_req_o = '0;
      i_res_o   = '0;
      d_res_o   = '0;
      if (state_q == ARB_BUSY) begin
         mem_req_o.addr  = addr_q;
         mem_req_o.data  = data_q;
         mem_req_o.rw    = rw_q;
         mem_req_o.valid = 1'b1;
         if (owner_q == OWN_D) d_res_o = mem_res_i;
         else                  i_res_o = mem_res_i;
      end
   end

   assign busy_o       = (state_q == ARB_BUSY);
   assign owner_o      = (owner_q == OWN_D);
   assign no_grant_i_o = cnt_i_q;
   assign no_grant_d_o = cnt_d_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter; instance 0 is round-robin, instance 1 fixed priority.
module tb_cache_mem_arbiter;
   import cache_mem_arbiter_pkg::*;

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0;
   mem_req_type  i_req, d_req;
   mem_data_type mem_res;
   mem_data_type i_res [2];
   mem_data_type d_res [2];
   mem_req_type  mem_req [2];
   logic [1:0]   busy, owner;
   logic [31:0]  cnt_i [2];
   logic [31:0]  cnt_d [2];

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   always #5 clk_i = ~clk_i;

   cache_mem_arbiter #(.ADDR_W(32), .LINE_W(128), .FIXED_PRIO(1'b0), .CNT_W(32)) u_dut_rr (
      .clk_i(clk_i), .rst_ni(rst_ni), .i_req_i(i_req), .i_res_o(i_res[0]), .d_req_i(d_req),
      .d_res_o(d_res[0]), .mem_req_o(mem_req[0]), .mem_res_i(mem_res), .busy_o(busy[0]),
      .owner_o(owner[0]), .no_grant_i_o(cnt_i[0]), .no_grant_d_o(cnt_d[0])
   );

   cache_mem_arbiter #(.ADDR_W(32), .LINE_W(128), .FIXED_PRIO(1'b1), .CNT_W(32)) u_dut_fx (
      .clk_i(clk_i), .rst_ni(rst_ni), .i_req_i(i_req), .i_res_o(i_res[1]), .d_req_i(d_req),
      .d_res_o(d_res[1]), .mem_req_o(mem_req[1]), .mem_res_i(mem_res), .busy_o(busy[1]),
      .owner_o(owner[1]), .no_grant_i_o(cnt_i[1]), .no_grant_d_o(cnt_d[1])
   );

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Transaction-level model: per instance, who holds memory and what it latched.
   logic        m_busy  [2];
   logic        m_owner [2];
   logic        m_ptr   [2];
   mem_req_type m_req   [2];
   logic [31:0] m_ci    [2];
   logic [31:0] m_cd    [2];
   int          g_log   [2][8];
   int          g_n     [2];

   function automatic int pick(int m, logic iv, logic dv, logic ptr);
      if (iv && dv) return (m == 1) ? 1 : (ptr ? 1 : 0);
      if (iv) return 0;
      if (dv) return 1;
      return -1;
   endfunction

   always @(posedge clk_i or negedge rst_ni) begin
      for (int m = 0; m < 2; m++) begin
         int w;
         if (!rst_ni) begin
            m_busy[m] <= 1'b0; m_owner[m] <= 1'b0; m_ptr[m] <= 1'b0;
            m_req[m] <= '0; m_ci[m] <= '0; m_cd[m] <= '0; g_n[m] <= 0;
         end else if (m_busy[m]) begin
            if (mem_res.ready) m_busy[m] <= 1'b0;
         end else begin
            w = pick(m, i_req.valid, d_req.valid, m_ptr[m]);
            if (w >= 0) begin
               m_busy[m]  <= 1'b1;
               m_owner[m] <= (w == 1);
               m_req[m]   <= (w == 1) ? d_req : i_req;
               m_req[m].valid <= 1'b1;
               if (w == 1) m_cd[m] <= m_cd[m] + 1;
               else        m_ci[m] <= m_ci[m] + 1;
               if (m == 0) m_ptr[m] <= (w == 0);
               if (g_n[m] < 8) g_log[m][g_n[m]] <= w;
               g_n[m] <= g_n[m] + 1;
            end
         end
      end
   end

   always @(negedge clk_i) begin
      if (cmp_en) begin
         for (int m = 0; m < 2; m++) begin
            mem_data_type ei, ed;
            ei = (m_busy[m] && !m_owner[m]) ? mem_res : '0;
            ed = (m_busy[m] &&  m_owner[m]) ? mem_res : '0;
            check($sformatf("busy[%0d]", m), 256'(busy[m]), 256'(m_busy[m]));
            check($sformatf("mem_req[%0d]", m), 256'(mem_req[m]),
                  m_busy[m] ? 256'(m_req[m]) : 256'(0));
            check($sformatf("i_res[%0d]", m), 256'(i_res[m]), 256'(ei));
            check($sformatf("d_res[%0d]", m), 256'(d_res[m]), 256'(ed));
            check($sformatf("cnt_i[%0d]", m), 256'(cnt_i[m]), 256'(m_ci[m]));
            check($sformatf("cnt_d[%0d]", m), 256'(cnt_d[m]), 256'(m_cd[m]));
            if (m_busy[m]) check($sformatf("owner[%0d]", m), 256'(owner[m]), 256'(m_owner[m]));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      step(2);
      rst_ni = 1'b1;
   endtask

   initial begin
      i_req = '0; d_req = '0; mem_res = '0;
      step(1);
      cmp_en = 1'b1;
      step(1);
      rst_ni = 1'b1;
      check("reset busy", 256'(busy), 256'(0));
      check("reset mem_req", 256'(mem_req[0]), 256'(0));
      check("reset cnt_i", 256'(cnt_i[0]), 256'(0));

      // Single I read, ready after 3 cycles.
      i_req = '{addr: 32'h0000_1000, data: '0, rw: 1'b0, valid: 1'b1};
      step(1);
      i_req.valid = 1'b0;
      check("t1 req addr", 256'(mem_req[0].addr), 256'(32'h0000_1000));
      check("t1 req valid/rw", 256'({mem_req[0].valid, mem_req[0].rw}), 256'(2'b10));
      step(2);
      mem_res = '{data: {16{8'hAA}}, ready: 1'b1};
      #1;
      check("t1 i_res", 256'(i_res[0]), 256'({{16{8'hAA}}, 1'b1}));
      check("t1 d_res ready", 256'(d_res[0].ready), 256'(0));
      check("t1 cnt_i", 256'(cnt_i[0]), 256'(1));
      step(1);
      mem_res = '0;
      check("t1 idle valid", 256'(mem_req[0].valid), 256'(0));

      // Simultaneous requests from reset, three transactions.
      do_reset();
      i_req = '{addr: 32'h0000_0100, data: {4{32'h1111_1111}}, rw: 1'b0, valid: 1'b1};
      d_req = '{addr: 32'h0000_0200, data: {4{32'h2222_2222}}, rw: 1'b1, valid: 1'b1};
      for (int k = 0; k < 3; k++) begin
         step(1);
         mem_res = '{data: {4{32'hC0DE_0000 | k}}, ready: 1'b1};
         step(1);
         mem_res = '0;
      end
      i_req.valid = 1'b0;
      d_req.valid = 1'b0;
      check("rr order0", 256'(g_log[0][0]), 256'(0));
      check("rr order1", 256'(g_log[0][1]), 256'(1));
      check("rr order2", 256'(g_log[0][2]), 256'(0));
      check("rr cnt_i", 256'(cnt_i[0]), 256'(2));
      check("rr cnt_d", 256'(cnt_d[0]), 256'(1));
      check("fx cnt_i", 256'(cnt_i[1]), 256'(0));
      check("fx cnt_d", 256'(cnt_d[1]), 256'(3));

      // D write-back; D changes its address and drops valid mid-transaction.
      step(1);
      d_req = '{addr: 32'h0000_2040, data: {4{32'h1234_5678}}, rw: 1'b1, valid: 1'b1};
      step(1);
      d_req.addr = 32'h0000_3040;
      d_req.valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("wb addr", 256'(mem_req[0].addr), 256'(32'h0000_2040));
         check("wb rw/valid", 256'({mem_req[0].rw, mem_req[0].valid}), 256'(2'b11));
         check("wb data", 256'(mem_req[0].data), 256'({4{32'h1234_5678}}));
         step(1);
      end
      mem_res = '{data: {4{32'h5A5A_5A5A}}, ready: 1'b1};
      #1;
      check("wb d_res ready", 256'(d_res[0].ready), 256'(1));
      step(1);
      mem_res = '0;

      // Stray ready while idle.
      step(1);
      mem_res = '{data: {4{32'hFFFF_FFFF}}, ready: 1'b1};
      step(1);
      check("idle ready busy", 256'(busy), 256'(0));
      check("idle ready i_res", 256'(i_res[0]), 256'(0));
      mem_res = '0;
      step(1);

      // Reset in the middle of a transaction, then a fresh I request.
      i_req = '{addr: 32'h0000_5000, data: '0, rw: 1'b0, valid: 1'b1};
      step(1);
      i_req.valid = 1'b0;
      step(1);
      rst_ni = 1'b0;
      #1;
      check("midrst valid", 256'({mem_req[1].valid, mem_req[0].valid}), 256'(0));
      check("midrst busy", 256'(busy), 256'(0));
      step(1);
      rst_ni = 1'b1;
      i_req = '{addr: 32'h0000_4000, data: '0, rw: 1'b0, valid: 1'b1};
      step(1);
      i_req.valid = 1'b0;
      check("post rst addr", 256'({mem_req[0].addr, mem_req[0].valid}), 256'({32'h4000, 1'b1}));
      check("post rst cnt_i", 256'(cnt_i[0]), 256'(1));
      mem_res = '{data: {4{32'h0BAD_F00D}}, ready: 1'b1};
      step(1);
      mem_res = '0;
      step(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
